// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and field positions
// for the SPI command decoder.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_ERR
  } state_e;

  localparam int CMD_R_BIT    = 7;
  localparam int CMD_ADDR_MSB = 2;
  localparam int NUM_REGS     = 8;

endpackage

// File: rtl/sync2_edge.sv
// sync2_edge: two-flop synchroniser followed by
// a registered rise/fall detector.
module sync2_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign level = s3_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns SPI bytes into register
// read/write commands; owns the register file.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0] RESET_VAL   = 8'h00,
  parameter logic [2:0] STATUS_ADDR = 3'd7
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        ss,
  input  logic [7:0]  rx_byte,
  input  logic        rx_rdy,
  input  logic [7:0]  status_in,
  output logic [7:0]  tx_byte,
  output logic        tx_latch,
  output logic [63:0] regs_flat,
  output logic        wr_strobe,
  output logic [2:0]  wr_addr,
  output logic        err
);

  localparam logic [2:0] LAST_ADDR = 3'(NUM_REGS - 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic rdy_lvl, byte_evt, rdy_fall;
  logic unused_sync;

  sync2_edge u_ss_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d_i   (ss),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  sync2_edge u_rdy_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d_i   (rx_rdy),
    .level (rdy_lvl),
    .rise  (byte_evt),
    .fall  (rdy_fall)
  );

  assign unused_sync = ^{ss_lvl, rdy_lvl, rdy_fall};

  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_w;
  logic [2:0] addr_q, addr_d;
  logic [2:0] wr_addr_q, wr_addr_d;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_latch_q, tx_latch_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       err_q, err_d;
  logic       we, wr_ok, bad_cmd;
  logic [7:0] regs_q [NUM_REGS];

  // rx_byte is stable while byte_evt is high
  assign byte_w  = byte_evt ? rx_byte : byte_q;
  assign bad_cmd = |byte_w[CMD_R_BIT-1:CMD_ADDR_MSB+1];
  assign rd_addr = (state_q == ST_CMD)
                 ? byte_w[CMD_ADDR_MSB:0] : addr_q;
  assign rd_data = (rd_addr == STATUS_ADDR)
                 ? status_in : regs_q[rd_addr];
  assign wr_ok   = (addr_q != STATUS_ADDR)
                 && (addr_q != LAST_ADDR);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tx_byte_d   = tx_byte_q;
    tx_latch_d  = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_d       = err_q;
    we          = 1'b0;
    if (ss_fall) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ss_rise) begin
            err_d   = 1'b0;
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          if (byte_evt) begin
            if (bad_cmd) begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end else if (byte_w[CMD_R_BIT]) begin
              tx_byte_d  = rd_data;
              tx_latch_d = 1'b1;
              addr_d     = rd_addr + 3'd1;
              state_d    = ST_READ;
            end else begin
              addr_d  = byte_w[CMD_ADDR_MSB:0];
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (byte_evt) begin
            addr_d = addr_q + 3'd1;
            if (wr_ok) begin
              we          = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_READ: begin
          if (byte_evt) begin
            tx_byte_d  = rd_data;
            tx_latch_d = 1'b1;
            addr_d     = addr_q + 3'd1;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      byte_q      <= 8'h00;
      addr_q      <= 3'd0;
      tx_byte_q   <= 8'h00;
      tx_latch_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_w;
      addr_q      <= addr_d;
      tx_byte_q   <= tx_byte_d;
      tx_latch_q  <= tx_latch_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= (k < NUM_REGS - 1)
                   ? RESET_VAL : 8'h00;
      end
    end else if (we) begin
      regs_q[addr_q] <= byte_w;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NUM_REGS - 1; k++) begin
      regs_flat[8*k +: 8] = regs_q[k];
    end
  end

  assign tx_byte   = tx_byte_q;
  assign tx_latch  = tx_latch_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: vector table, directed corner
// cases and random frames against a frame-level model.
module tb_spi_cmd_decoder;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [7:0]  status_in = 8'h00;
  logic [7:0]  tx_byte;
  logic        tx_latch;
  logic [63:0] regs_flat;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  spi_cmd_decoder #(
    .RESET_VAL   (8'h3C),
    .STATUS_ADDR (3'd7)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .ss        (ss),
    .rx_byte   (rx_byte),
    .rx_rdy    (rx_rdy),
    .status_in (status_in),
    .tx_byte   (tx_byte),
    .tx_latch  (tx_latch),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .err       (err)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  logic [7:0] got_tx[$];
  int         got_wr[$];
  logic       prev_lat = 1'b0;
  logic       prev_wr = 1'b0;

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (tx_latch) begin
        got_tx.push_back(tx_byte);
        chk("latch_width", 64'(prev_lat), 0);
      end
      if (wr_strobe) begin
        got_wr.push_back(int'(wr_addr));
        chk("strobe_width", 64'(prev_wr), 0);
      end
    end
    prev_lat = tx_latch;
    prev_wr  = wr_strobe;
  end

  // Frame-level reference model
  logic [7:0] mem[8];
  logic [7:0] frame[$];
  logic [7:0] exp_tx[$];
  int         exp_wr[$];
  logic       exp_err;

  task automatic model_reset();
    for (int k = 0; k < 8; k++)
      mem[k] = (k < 7) ? 8'h3C : 8'h00;
    exp_err = 1'b0;
  endtask

  function automatic logic [7:0] m_rd(int a);
    return (a == 7) ? status_in : mem[a];
  endfunction

  function automatic logic [63:0] m_regs();
    logic [63:0] r = '0;
    for (int k = 0; k < 7; k++) r[8*k +: 8] = mem[k];
    return r;
  endfunction

  task automatic model_frame();
    int mode = 0;
    int a = 0;
    exp_err = 1'b0;
    exp_tx.delete();
    exp_wr.delete();
    foreach (frame[i]) begin
      logic [7:0] b = frame[i];
      if (mode == 0) begin
        a = int'(b) % 8;
        if ((b & 8'h78) != 0) begin
          exp_err = 1'b1;
          mode = 3;
        end else if (b >= 8'h80) begin
          exp_tx.push_back(m_rd(a));
          a = (a + 1) % 8;
          mode = 2;
        end else begin
          mode = 1;
        end
      end else if (mode == 1) begin
        if (a == 7) exp_err = 1'b1;
        else begin
          mem[a] = b;
          exp_wr.push_back(a);
        end
        a = (a + 1) % 8;
      end else if (mode == 2) begin
        exp_tx.push_back(m_rd(a));
        a = (a + 1) % 8;
      end
    end
  endtask

  task automatic clks(int n);
    repeat (n) @(posedge sys_clk);
  endtask

  task automatic ss_up();
    @(negedge sys_clk);
    ss = 1'b1;
    clks(6);
  endtask

  task automatic ss_dn();
    @(negedge sys_clk);
    ss = 1'b0;
    clks(6);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    rx_byte = b;
    rx_rdy = 1'b1;
    clks(6);
    @(negedge sys_clk);
    rx_rdy = 1'b0;
    clks(6);
  endtask

  task automatic compare();
    chk("err", 64'(err), 64'(exp_err));
    chk("regs", regs_flat, m_regs());
    chk("tx_count", got_tx.size(), exp_tx.size());
    foreach (exp_tx[i])
      chk("tx_byte", got_tx[i], exp_tx[i]);
    chk("wr_count", got_wr.size(), exp_wr.size());
    foreach (exp_wr[i])
      chk("wr_addr", got_wr[i], exp_wr[i]);
  endtask

  task automatic run_frame();
    got_tx.delete();
    got_wr.delete();
    model_frame();
    ss_up();
    foreach (frame[i]) send(frame[i]);
    ss_dn();
    @(negedge sys_clk);
    compare();
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic       e_err;
    int         e_wr;
    int         e_lat;
    int         e_wa;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h02, 8'hA7, 1'b0, 1, 0, 2};
    tbl[1] = '{8'h48, 8'hFF, 1'b1, 0, 0, 0};
    tbl[2] = '{8'h07, 8'h99, 1'b1, 0, 0, 0};
    tbl[3] = '{8'h85, 8'h00, 1'b0, 0, 2, 0};
    tbl[4] = '{8'h06, 8'h55, 1'b0, 1, 0, 6};

    model_reset();
    clks(3);
    @(negedge sys_clk);
    chk("rst_regs", regs_flat, 64'h003C3C3C3C3C3C3C);
    chk("rst_tx_byte", 64'(tx_byte), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_strobe", 64'(wr_strobe), 0);
    chk("rst_latch", 64'(tx_latch), 0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    rst_n = 1'b1;
    clks(3);

    foreach (tbl[r]) begin
      frame.delete();
      frame.push_back(tbl[r].cmd);
      frame.push_back(tbl[r].dat);
      run_frame();
      chk("vec_err", 64'(err), 64'(tbl[r].e_err));
      chk("vec_wr", got_wr.size(), tbl[r].e_wr);
      chk("vec_lat", got_tx.size(), tbl[r].e_lat);
      if (tbl[r].e_wr > 0) begin
        chk("vec_waddr", 64'(wr_addr), tbl[r].e_wa);
        chk("vec_wdata", regs_flat[8*tbl[r].e_wa +: 8],
            64'(tbl[r].dat));
      end
    end

    frame = '{8'h48, 8'hFF};
    run_frame();
    chk("bad_err_set", 64'(err), 1);
    ss_up();
    chk("err_clear", 64'(err), 0);
    ss_dn();

    frame = '{8'h06, 8'h11};
    run_frame();
    status_in = 8'h5A;
    frame = '{8'h86, 8'h00, 8'h00};
    run_frame();
    chk("burst0", got_tx[0], 8'h11);
    chk("burst1", got_tx[1], 8'h5A);
    chk("burst2", got_tx[2], mem[0]);

    got_tx.delete();
    ss_up();
    @(negedge sys_clk);
    rx_byte = 8'h81;
    rx_rdy = 1'b1;
    clks(3);
    @(negedge sys_clk);
    chk("lat_early", 64'(tx_latch), 0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("lat_edge4", 64'(tx_latch), 1);
    chk("lat_data", 64'(tx_byte), 64'(mem[1]));
    rx_rdy = 1'b0;
    clks(6);
    @(negedge sys_clk);
    chk("tx_hold", 64'(tx_byte), 64'(mem[1]));
    ss_dn();

    got_tx.delete();
    got_wr.delete();
    frame = '{8'h07, 8'h99};
    model_frame();
    ss_up();
    send(8'h07);
    send(8'h99);
    chk("stat_wr_err", 64'(err), 1);
    chk("stat_wr_nostb", got_wr.size(), 0);
    @(negedge sys_clk);
    rx_byte = 8'hEE;
    rx_rdy = 1'b1;
    ss = 1'b0;
    clks(8);
    @(negedge sys_clk);
    rx_rdy = 1'b0;
    clks(6);
    @(negedge sys_clk);
    compare();
    frame = '{8'h01, 8'h3D};
    run_frame();

    for (int t = 0; t < 40; t++) begin
      int n;
      logic [7:0] c;
      status_in = 8'($urandom);
      frame.delete();
      c = 8'($urandom);
      if ($urandom_range(0, 7) != 0) c = c & 8'h87;
      frame.push_back(c);
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++)
        frame.push_back(8'($urandom));
      run_frame();
    end

    ss_up();
    send(8'h03);
    @(negedge sys_clk);
    rx_byte = 8'h77;
    rx_rdy = 1'b1;
    clks(1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_regs", regs_flat, m_regs());
    chk("arst_tx", 64'(tx_byte), 0);
    chk("arst_err", 64'(err), 0);
    chk("arst_strobe", 64'(wr_strobe), 0);
    ss = 1'b0;
    rx_rdy = 1'b0;
    clks(2);
    @(negedge sys_clk);
    rst_n = 1'b1;
    clks(4);
    frame = '{8'h04, 8'hC3};
    run_frame();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Byte-level command decoder sitting directly downstream of `spi_slave`. It consumes received bytes (`spi_data_out` / `data_rdy`), interprets them as register read/write commands framed by `ss`, and maintains a small register file. It returns read data to the slave through `spi_data_in` / `data_latch`. All logic runs on `sys_clk`; SPI-domain inputs are synchronised internally.

## Interface
- `RESET_VAL`, default 8'h00: reset value of writable registers 0..6.
- `STATUS_ADDR`, default 3'd7: read-only address that returns `status_in`.
- `sys_clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ss`  in  1  slave select, active-high, same net as the slave's `ss`; asynchronous to `sys_clk`.
- `rx_byte`  in  8  received byte, from `spi_data_out`.
- `rx_rdy`  in  1  byte-complete level, from `data_rdy`; asynchronous.
- `status_in`  in  8  live status value, read at `STATUS_ADDR`.
- `tx_byte`  out  8  response byte, to `spi_data_in`.
- `tx_latch`  out  1  one-cycle load pulse, to `data_latch`.
- `regs_flat`  out  64  registers 0..7 concatenated; reg k occupies bits [8k+7:8k]; slot 7 reads 0.
- `wr_strobe`  out  1  one-cycle pulse per completed register write.
- `wr_addr`  out  3  address of the last write; valid with `wr_strobe`.
- `err`  out  1  protocol error flag; cleared at each frame start.

## Operation
- Synchronise `ss` and `rx_rdy` with two flops each, then edge-detect:
  - `ss_rise` / `ss_fall` from the synchronised `ss`.
  - `byte_evt` = rising edge of the synchronised `rx_rdy`.
- On `byte_evt`, capture `rx_byte` into `byte_q`.
- Command byte format:
  - bit7 = R (1 = read).
  - bits6:3 must be 0; a nonzero value sets `err` and moves to ERR.
  - bits2:0 = start address.
- FSM states:
  - IDLE: wait for `ss_rise`. On `ss_rise`, clear `err` and go to CMD.
  - CMD: on `byte_evt`, decode the command and load `addr_q`.
    - Read: load `tx_byte` from register `addr_q`, pulse `tx_latch`, increment `addr_q`, go to READ.
    - Write: go to WRITE.
  - WRITE: each `byte_evt` writes `byte_q` to reg `addr_q`, pulses `wr_strobe`, sets `wr_addr` = `addr_q`, and increments `addr_q`.
    - A write to `STATUS_ADDR` is discarded: no strobe, `err` set, `addr_q` still increments.
  - READ: each `byte_evt` (a dummy byte) reloads `tx_byte` from `addr_q`, pulses `tx_latch`, and increments `addr_q`.
  - ERR: ignore all bytes until `ss_fall`.
- `ss_fall` in any state goes to IDLE. Writes already committed are kept.
- `addr_q` is 3 bits and wraps 7→0 (burst wrap).
- Reads of `STATUS_ADDR` return `status_in` sampled in the load cycle.

## Timing
- Reset values: state IDLE, registers 0..6 = `RESET_VAL`, `tx_byte` = 0, `tx_latch` = 0, `wr_strobe` = 0, `wr_addr` = 0, `err` = 0, sync flops 0.
- Input-to-event latency: `byte_evt` asserts 3 `sys_clk` edges after `rx_rdy` rises (2 sync + 1 edge register). `ss_rise` / `ss_fall` follow the same latency.
- Output latency: `tx_latch`, `tx_byte` update, register write and `wr_strobe` all occur 1 cycle after `byte_evt`.
- `tx_byte` holds its value until the next `tx_latch`. `tx_latch` and `wr_strobe` are never asserted more than 1 cycle.
- Constraint: SPI bit period ≥ 4 `sys_clk` cycles, so `rx_byte` is stable when captured.
- Simultaneous `ss_fall` and `byte_evt` in the same cycle: `ss_fall` wins, the byte is dropped, no write or latch occurs.
- `ss_rise` while not in IDLE cannot occur without a prior `ss_fall`. If the synchroniser yields both edges back to back, process them in order.
- Reset asserted mid-burst: everything returns to reset values immediately and asynchronously. There are no partial writes, because a write is a single-cycle update.

## Structure
- Package `spi_cmd_pkg` holds:
  - the state encoding (IDLE, CMD, WRITE, READ, ERR);
  - command field positions (`CMD_R_BIT` = 7, `CMD_ADDR_MSB` = 2);
  - `NUM_REGS` = 8.
- Sub-module `sync2_edge`: 2-flop synchroniser plus edge register, with outputs `level`, `rise`, `fall`. Instantiate it once for `ss` and once for `rx_rdy`.
- The register file and FSM live in the top module.

## Test plan
- Reset: hold `rst_n` = 0 with `RESET_VAL` = 8'h3C. Required: `regs_flat[55:0]` = all 8'h3C, `tx_byte` = 0, `err` = 0.
- Single write: `ss` high, bytes 8'h02 then 8'hA7. Required: reg2 = 8'hA7, one `wr_strobe` with `wr_addr` = 2, `tx_latch` never pulses.
- Read burst with wrap:
  - Preload reg6 = 8'h11, drive `status_in` = 8'h5A.
  - Send bytes 8'h86, dummy, dummy.
  - Required: `tx_byte` sequence 8'h11, 8'h5A, then the reg0 value, each with a single `tx_latch` pulse.
- Bad command: send 8'h48 then 8'hFF. Required: `err` = 1, no write occurs, `err` clears on the next `ss_rise`.
- Write to `STATUS_ADDR` and abort:
  - Send 8'h07, 8'h99. Required: no strobe, `err` = 1.
  - Then drop `ss` in the same cycle as a `byte_evt`. Required: the byte is dropped and the state returns to IDLE.
